// File: rtl/chip8_keypad_pkg.sv
// Shared constants for the CHIP-8 4x4 keypad scanner.
package chip8_keypad_pkg;

    localparam int unsigned NUM_KEYS = 16;
    localparam int unsigned KEY_W    = 4;
    localparam int unsigned NKD_W    = 5;

    // Value of newest_key_down when no press is latched.
    localparam logic [NKD_W-1:0] KEY_NONE = 5'd16;

    // Physical position (row*4 + col) to CHIP-8 key, row-major layout:
    //   1 2 3 C / 4 5 6 D / 7 8 9 E / A 0 B F
    localparam logic [KEY_W-1:0] POS_TO_KEY [NUM_KEYS] = '{
        4'h1, 4'h2, 4'h3, 4'hC,
        4'h4, 4'h5, 4'h6, 4'hD,
        4'h7, 4'h8, 4'h9, 4'hE,
        4'hA, 4'h0, 4'hB, 4'hF
    };

    // Inverse of POS_TO_KEY: CHIP-8 key to physical position.
    localparam logic [KEY_W-1:0] KEY_TO_POS [NUM_KEYS] = '{
        4'd13, 4'd0,  4'd1,  4'd2,
        4'd4,  4'd5,  4'd6,  4'd8,
        4'd9,  4'd10, 4'd12, 4'd14,
        4'd3,  4'd7,  4'd11, 4'd15
    };

endpackage

// File: rtl/chip8_keypad_debounce.sv
// Per-position debouncer: the stable state flips only after DEBOUNCE_SCANS
// consecutive full scans disagree with it.
module keypad_debounce #(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scan_done,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             w_flip;

    // Flip happens on the scan that completes the disagreeing run.
    assign w_flip   = i_scan_done && (i_raw != r_stable) &&
                      (r_cnt == CNT_W'(DEBOUNCE_SCANS - 1));
    assign o_rise_c = w_flip && i_raw;
    assign o_stable = r_stable;

    // Disagreement run counter and stable state, advanced once per full scan.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (i_scan_done) begin
            if (i_raw == r_stable) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_stable <= i_raw;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/chip8_keypad.sv
// 4x4 hex keypad scanner: row drive, column sync, debounce, CHIP-8 key
// mapping and newest-press latch with clear handshake.
module chip8_keypad
    import chip8_keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [3:0]          rows_n,
    input  logic [3:0]          cols_n,
    input  logic                clear_newest_key_down,
    output logic [NUM_KEYS-1:0] input_keys,
    output logic [NKD_W-1:0]    newest_key_down
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    logic [3:0]          r_sync1;
    logic [3:0]          r_sync2;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [1:0]          r_row_idx;
    logic [3:0]          r_rows_n;
    logic [NUM_KEYS-1:0] r_raw;
    logic                r_scan_done;
    logic [NKD_W-1:0]    r_newest;

    logic                w_sample;
    logic [NUM_KEYS-1:0] w_stable_pos;
    logic [NUM_KEYS-1:0] w_rise_pos;
    logic [NUM_KEYS-1:0] w_rise_key;
    logic                w_press_any;
    logic [KEY_W-1:0]    w_press_key;

    assign w_sample = (r_div_cnt == DIV_W'(SCAN_DIV - 1));

    // Column synchronizer, row scan counter and raw key image capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1     <= 4'b1111;
            r_sync2     <= 4'b1111;
            r_div_cnt   <= '0;
            r_row_idx   <= 2'd0;
            r_rows_n    <= 4'b1111;
            r_raw       <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_sync1     <= cols_n;
            r_sync2     <= r_sync1;
            r_rows_n    <= ~(4'b0001 << r_row_idx);
            r_scan_done <= 1'b0;
            if (w_sample) begin
                r_raw[{r_row_idx, 2'b00} +: 4] <= ~r_sync2;
                r_div_cnt   <= '0;
                r_row_idx   <= r_row_idx + 2'd1;
                r_scan_done <= (r_row_idx == 2'd3);
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    for (genvar p = 0; p < NUM_KEYS; p++) begin : g_pos
        keypad_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_debounce (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_scan_done (r_scan_done),
            .i_raw       (r_raw[p]),
            .o_stable    (w_stable_pos[p]),
            .o_rise_c    (w_rise_pos[p])
        );
        assign w_rise_key[POS_TO_KEY[p]] = w_rise_pos[p];
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        assign input_keys[k] = w_stable_pos[KEY_TO_POS[k]];
    end

    // Lowest-numbered CHIP-8 key among this scan's press events.
    always_comb begin
        w_press_any = 1'b0;
        w_press_key = '0;
        for (int k = int'(NUM_KEYS) - 1; k >= 0; k--) begin
            if (w_rise_key[k]) begin
                w_press_any = 1'b1;
                w_press_key = KEY_W'(k);
            end
        end
    end

    // Newest-press latch; a press event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_newest <= KEY_NONE;
        end else if (w_press_any) begin
            r_newest <= {1'b0, w_press_key};
        end else if (clear_newest_key_down) begin
            r_newest <= KEY_NONE;
        end
    end

    assign rows_n          = r_rows_n;
    assign newest_key_down = r_newest;

endmodule

// File: tb/tb_chip8_keypad.sv
// Self-checking bench for chip8_keypad with a scan-level keypad model.
module tb_chip8_keypad;

    localparam int SD = 4;
    localparam int DB = 2;
    localparam int SCAN_CLKS = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rows_n;
    logic [3:0]  cols_n;
    logic        clear = 1'b0;
    logic [15:0] input_keys;
    logic [4:0]  newest_key_down;

    logic [15:0] held = '0;
    logic        force_cols = 1'b0;
    int          layout [16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};

    int total = 0;
    int bad   = 0;

    // Reference model state, indexed by CHIP-8 key.
    logic [15:0] m_keys;
    logic [4:0]  m_newest;
    logic [7:0]  m_hist [16];

    typedef struct {
        logic [15:0] held;
        int          clr;
        logic [15:0] exp_keys;
        logic [4:0]  exp_newest;
    } vec_t;

    vec_t vecs [16];

    chip8_keypad #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .rows_n                (rows_n),
        .cols_n                (cols_n),
        .clear_newest_key_down (clear),
        .input_keys            (input_keys),
        .newest_key_down       (newest_key_down)
    );

    always #5 clk = ~clk;

    // Passive matrix: a column reads low when a held key sits on a driven row.
    always_comb begin
        cols_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows_n[r] && held[layout[r*4+c]]) cols_n[c] = 1'b0;
        if (force_cols) cols_n = 4'b0000;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_keys   = '0;
        m_newest = 5'd16;
        for (int k = 0; k < 16; k++) m_hist[k] = '0;
    endtask

    // One full scan: a key flips once its last DB samples all differ from it.
    task automatic model_scan(input logic [15:0] h, input int clr);
        logic [7:0]  mask;
        logic [7:0]  win;
        logic [15:0] rise;
        mask = 8'((1 << DB) - 1);
        rise = '0;
        if (clr == 1) m_newest = 5'd16;
        for (int k = 0; k < 16; k++) begin
            m_hist[k] = {m_hist[k][6:0], h[k]};
            win = m_hist[k] & mask;
            if ((m_keys[k] && win == 8'd0) || (!m_keys[k] && win == mask)) begin
                m_keys[k] = ~m_keys[k];
                if (m_keys[k]) rise[k] = 1'b1;
            end
        end
        if (rise != 0) begin
            for (int k = 15; k >= 0; k--) if (rise[k]) m_newest = 5'(k);
        end else if (clr == 2) begin
            m_newest = 5'd16;
        end
    endtask

    // Enter aligned to the cycle after a scan's first row edge; leave one scan later.
    // clr: 0 none, 1 mid-scan clear pulse, 2 clear coinciding with the debounce update.
    task automatic run_scan(input logic [15:0] h, input int clr);
        held = h;
        for (int i = 1; i <= SCAN_CLKS; i++) begin
            if ((clr == 1 && i == 5) || (clr == 2 && i == SCAN_CLKS)) clear = 1'b1;
            tick();
            clear = 1'b0;
            if (clr == 1 && i == 5) begin
                chk("mid_clear_newest", 32'(newest_key_down), 32'd16);
                chk("mid_scan_keys", 32'(input_keys), 32'(m_keys));
            end
        end
        model_scan(h, clr);
        chk("model_keys", 32'(input_keys), 32'(m_keys));
        chk("model_newest", 32'(newest_key_down), 32'(m_newest));
    endtask

    // Hold reset for n clks checking reset outputs, then release aligned for run_scan.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("rst_rows", 32'(rows_n), 32'hF);
            chk("rst_keys", 32'(input_keys), 32'h0);
            chk("rst_newest", 32'(newest_key_down), 32'd16);
        end
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    initial begin
        logic [15:0] h;
        int          clr;

        vecs[0]  = '{16'h0001, 0, 16'h0000, 5'd16};
        vecs[1]  = '{16'h0000, 0, 16'h0000, 5'd16};
        vecs[2]  = '{16'h0000, 0, 16'h0000, 5'd16};
        vecs[3]  = '{16'h0010, 0, 16'h0000, 5'd16};
        vecs[4]  = '{16'h0010, 0, 16'h0010, 5'd4};
        vecs[5]  = '{16'h0000, 0, 16'h0010, 5'd4};
        vecs[6]  = '{16'h0000, 0, 16'h0000, 5'd4};
        vecs[7]  = '{16'h1080, 0, 16'h0000, 5'd4};
        vecs[8]  = '{16'h1080, 0, 16'h1080, 5'd7};
        vecs[9]  = '{16'h1080, 1, 16'h1080, 5'd16};
        vecs[10] = '{16'h9080, 0, 16'h1080, 5'd16};
        vecs[11] = '{16'h9080, 2, 16'h9080, 5'd15};
        vecs[12] = '{16'h9080, 1, 16'h9080, 5'd16};
        vecs[13] = '{16'h9080, 2, 16'h9080, 5'd16};
        vecs[14] = '{16'h0000, 0, 16'h9080, 5'd16};
        vecs[15] = '{16'h0000, 0, 16'h0000, 5'd16};

        // Reset with all columns pulled low, then first row timing.
        force_cols = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst5_rows", 32'(rows_n), 32'hF);
            chk("rst5_keys", 32'(input_keys), 32'h0);
            chk("rst5_newest", 32'(newest_key_down), 32'd16);
        end
        rst_n = 1'b1;
        force_cols = 1'b0;
        for (int i = 0; i < SD; i++) begin
            tick();
            chk("row0_drive", 32'(rows_n), 32'hE);
        end
        tick();
        chk("row1_drive", 32'(rows_n), 32'hD);

        // Directed vector table.
        do_reset(2);
        for (int v = 0; v < 16; v++) begin
            run_scan(vecs[v].held, vecs[v].clr);
            chk($sformatf("vec%0d_keys", v), 32'(input_keys), 32'(vecs[v].exp_keys));
            chk($sformatf("vec%0d_newest", v), 32'(newest_key_down), 32'(vecs[v].exp_newest));
        end

        // Reset in the middle of debouncing key 5.
        do_reset(2);
        run_scan(16'h0020, 0);
        chk("k5_partial", 32'(input_keys), 32'h0);
        do_reset(3);
        run_scan(16'h0020, 0);
        chk("k5_restart", 32'(input_keys), 32'h0);
        run_scan(16'h0020, 0);
        chk("k5_keys", 32'(input_keys), 32'h0020);
        chk("k5_newest", 32'(newest_key_down), 32'd5);

        // Randomized held-key patterns and clear pulses against the model.
        do_reset(2);
        h = '0;
        for (int s = 0; s < 150; s++) begin
            h = h ^ 16'($urandom & $urandom & $urandom);
            clr = int'($urandom_range(0, 3));
            if (clr == 3) clr = 0;
            run_scan(h, clr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chip8_keypad.md
Name: chip8_keypad

Overview:
Drives the physical 4x4 hex keypad matrix and produces the key-state interface consumed by chip8: input_keys, newest_key_down and the clear_newest_key_down handshake. It replaces the constant key stimulus used in simulation with a real scanned, debounced source. It sits between the board pins and the chip8 core, in the core's clock domain.

Parameters:
SCAN_DIV, 16, clocks each row is driven; cols sampled on last clock of the row period; must be >= 4.
DEBOUNCE_SCANS, 4, consecutive full scans a key must disagree with its stable state before the stable state flips; must be >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
rows_n  output  4  row drive, active-low, one-hot-low while scanning
cols_n  input  4  column sense, active-low (board pull-ups), asynchronous
clear_newest_key_down  input  1  from chip8; high for one clk consumes the latched newest key
input_keys  output  16  bit k = CHIP-8 key k currently held (debounced)
newest_key_down  output  5  most recent newly pressed CHIP-8 key 0..15; 16 = none

Behaviour:
- Reset (rst_n low at a clk edge): rows_n=4'b1111, input_keys=0, newest_key_down=16, row_idx=0, div_cnt=0, sync flops=4'b1111, all debounce counters 0, raw image 0. Reset mid-scan discards partial scan and any pending press.
- cols_n passes through a 2-flop synchronizer; raw = ~synced value (1 = pressed).
- Scan: div_cnt counts 0..SCAN_DIV-1; rows_n = ~(4'b0001 << row_idx). At div_cnt==SCAN_DIV-1: raw[row_idx*4+c] <= pressed[c] for c=0..3, div_cnt<=0, row_idx<=row_idx+1 (wraps 3->0). First row drive is the cycle after reset release.
- scan_done pulses one clk after the row-3 sample, i.e. every 4*SCAN_DIV clks.
- Debounce, per physical position p, updated only on scan_done: if raw[p]==stable[p], cnt<=0; else if cnt==DEBOUNCE_SCANS-1, stable[p]<=raw[p], cnt<=0; else cnt<=cnt+1. Width clog2(DEBOUNCE_SCANS+1). Any single disagreeing scan followed by agreement resets cnt (glitch rejected).
- Mapping physical (row,col) to CHIP-8 key, row-major: 1 2 3 C / 4 5 6 D / 7 8 9 E / A 0 B F. input_keys[key] = stable[pos]; registered, changes only the clk after scan_done.
- Press event: stable 0->1 transition of any position at a scan_done update. newest_key_down <= CHIP-8 key index of the event; several simultaneous events -> lowest CHIP-8 key index wins. Releases never change newest_key_down.
- Clear: clear_newest_key_down high -> newest_key_down<=16 next clk. Press event in the same clk as clear -> press wins (new key latched, no loss). Clear while already 16 -> no effect.
- Latched key persists until cleared or overwritten by a later press, even after release.
- Latency: stable press seen at row sample to input_keys set: between (DEBOUNCE_SCANS-1)*4*SCAN_DIV and DEBOUNCE_SCANS*4*SCAN_DIV + SCAN_DIV + 4 clks.
- Ghosting (3+ keys forming a rectangle) is not corrected; reported as scanned.

Decomposition:
- Package chip8_keypad_pkg: KEY_NONE = 5'd16, NUM_KEYS = 16, constant table POS_TO_KEY[16] (physical position -> CHIP-8 key) and its inverse KEY_TO_POS.
- Sub-module keypad_debounce (one per position, 16 instances): inputs clk, rst_n, scan_done, raw; output stable, rise pulse; parameter DEBOUNCE_SCANS.
- Top holds synchronizer, scan counter, mapping, priority encoder and newest-key latch.

Test Plan:
- Reset: hold rst_n=0 for 5 clks with cols_n=4'b0000 -> rows_n=4'b1111, input_keys=0, newest_key_down=16 throughout; after release rows_n=4'b1110 for 16 clks then 4'b1101.
- Single press (SCAN_DIV=4, DEBOUNCE_SCANS=2): model pulls col0 low while row1 driven (CHIP-8 key 4) -> input_keys=16'h0010 within 36 clks, newest_key_down=4; release -> input_keys=0 within 36 clks, newest_key_down stays 4.
- Glitch: key position (3,1) (key 0) asserted for exactly one scan -> input_keys stays 0, newest_key_down stays 16.
- Simultaneous: keys at (0,3) (C) and (2,0) (7) pressed in same clk -> both input_keys bits 12 and 7 set in same cycle, newest_key_down=7.
- Clear handshake: latched 7, pulse clear -> 16 next clk; pulse clear in exact clk of key F press event -> newest_key_down=15.
- Reset mid-debounce: press key 5, assert rst_n low after 1 scan -> all outputs at reset values; key held after release re-debounces from zero (full latency again).
